// File: rtl/key_load_pkg.sv
// Shared types for the c499 serial key-load controller: FSM state encoding
// and the default key width (4 MUX-key bits + 12 XOR-key bits).
package key_load_pkg;

  localparam int KEY_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT,
    LOCKOUT
  } state_t;

endpackage : key_load_pkg

// File: rtl/key_load_ctrl_if.sv
// Bit-serial valid/ready key link: the key source is the master and the
// controller is the slave.
interface key_load_ctrl_if;

  logic ser_valid;
  logic ser_data;
  logic ser_ready;

  modport master (output ser_valid, output ser_data, input ser_ready);
  modport slave  (input ser_valid, input ser_data, output ser_ready);

endinterface : key_load_ctrl_if

// File: rtl/key_shift_reg.sv
// LSB-first key shift register with a bit counter; last flags that the next
// accepted bit completes the key.
module key_shift_reg #(
  parameter int KEY_W = 16,
  parameter int CNT_W = $clog2(KEY_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [KEY_W-1:0] q,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the key register is reset too, so a partial key never
  // leaks out after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (clear) begin
      q   <= '0;
      cnt <= '0;
    end else if (shift) begin
      q   <= {din, q[KEY_W-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(KEY_W - 1));

endmodule : key_shift_reg

// File: rtl/key_load_ctrl.sv
// Serial key-load controller for the logic-locked c499 datapath. Define
// KEY_LOAD_PARITY_EN to build the trailing parity check, retry count and lockout.
module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int MAX_TRIES = 3,
  parameter int CNT_W     = $clog2(KEY_W),
  parameter int ATT_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  key_load_ctrl_if.slave   ser,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic [ATT_W-1:0] attempts
);

  state_t           state, state_nxt;
  logic [KEY_W-1:0] sreg;
  logic             last;
  logic             hs;
  logic             sr_clear, sr_shift;
  logic             key_clr, key_load, lock;

`ifdef KEY_LOAD_PARITY_EN
  localparam logic [ATT_W-1:0] TRIES_LIM = ATT_W'(MAX_TRIES);
  logic [ATT_W-1:0] att_q;
  logic             fail;
  logic             err_q;
`endif

  assign ser.ser_ready = (state == SHIFT) || (state == CHECK);
  assign busy          = ser.ser_ready || (state == COMMIT);
  assign hs            = ser.ser_valid && ser.ser_ready;

  key_shift_reg #(
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) u_shift_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(sr_clear),
    .shift(sr_shift),
    .din  (ser.ser_data),
    .q    (sreg),
    .last (last)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    sr_clear  = 1'b0;
    sr_shift  = 1'b0;
    key_clr   = 1'b0;
    key_load  = 1'b0;
    lock      = 1'b0;
`ifdef KEY_LOAD_PARITY_EN
    fail      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          sr_clear  = 1'b1;
          key_clr   = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
          sr_clear  = 1'b1;
        end else if (hs) begin
          sr_shift = 1'b1;
          if (last) begin
`ifdef KEY_LOAD_PARITY_EN
            state_nxt = CHECK;
`else
            state_nxt = COMMIT;
`endif
          end
        end
      end
`ifdef KEY_LOAD_PARITY_EN
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
          sr_clear  = 1'b1;
        end else if (hs) begin
          // Even parity across key and parity bit: the bit must equal ^key.
          if (ser.ser_data == ^sreg) begin
            state_nxt = COMMIT;
          end else begin
            fail = 1'b1;
            if (att_q + 1'b1 == TRIES_LIM) begin
              state_nxt = LOCKOUT;
              lock      = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      LOCKOUT: state_nxt = LOCKOUT;
`endif
      COMMIT: begin
        key_load  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (key_clr || lock) begin
        key_out   <= '0;
        key_valid <= 1'b0;
      end else if (key_load) begin
        key_out   <= sreg;
        key_valid <= 1'b1;
      end
    end
  end

`ifdef KEY_LOAD_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      att_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (key_load) begin
        att_q <= '0;
      end else if (fail) begin
        att_q <= att_q + 1'b1;
      end
      if (lock) begin
        err_q <= 1'b1;
      end
    end
  end

  assign attempts = att_q;
  assign err      = err_q;
`else
  assign attempts = '0;
  assign err      = 1'b0;
`endif

endmodule : key_load_ctrl

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl; follows KEY_LOAD_PARITY_EN so the same
// file exercises both the parity and the plain build.
module tb_key_load_ctrl;

  localparam int KEY_W = 16;
  localparam int ATT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;
  logic [ATT_W-1:0] attempts;

  int n_assert = 0;
  int n_fail   = 0;

  key_load_ctrl_if sif ();

  key_load_ctrl #(
    .KEY_W    (KEY_W),
    .MAX_TRIES(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .ser      (sif),
    .key_out  (key_out),
    .key_valid(key_valid),
    .busy     (busy),
    .err      (err),
    .attempts (attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [KEY_W-1:0] key, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sif.ser_valid = 1'b1;
      sif.ser_data  = key[i];
      step();
    end
    sif.ser_valid = 1'b0;
    sif.ser_data  = 1'b0;
  endtask

  task automatic load(input logic [KEY_W-1:0] key);
    begin_load();
    send_bits(key, KEY_W);
  endtask

  task automatic send_parity(input logic par);
    sif.ser_valid = 1'b1;
    sif.ser_data  = par;
    step();
    sif.ser_valid = 1'b0;
    sif.ser_data  = 1'b0;
  endtask

  // Finishes a load whose key bits are already in; ends one cycle after COMMIT.
  task automatic finish_load(input logic par, input string tag);
`ifdef KEY_LOAD_PARITY_EN
    send_parity(par);
`endif
    check({tag, "_commit_busy"}, 32'(busy), 32'd1);
    check({tag, "_commit_kv"}, 32'(key_valid), 32'd0);
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    sif.ser_valid = 1'b0;
    sif.ser_data  = 1'b0;
    #2;
    check("rst_key_out", 32'(key_out), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(sif.ser_ready), 32'd0);
    check("rst_attempts", 32'(attempts), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic load of 0xA5C3 (eight ones -> parity 0).
    begin_load();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(sif.ser_ready), 32'd1);
    send_bits(16'hA5C3, KEY_W);
`ifdef KEY_LOAD_PARITY_EN
    check("t1_check_ready", 32'(sif.ser_ready), 32'd1);
`endif
    finish_load(1'b0, "t1");
    check("t1_key_valid", 32'(key_valid), 32'd1);
    check("t1_key_out", 32'(key_out), 32'hA5C3);
    check("t1_attempts", 32'(attempts), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

`ifdef KEY_LOAD_PARITY_EN
    // Three bad parities in a row lock the controller out.
    begin_load();
    check("t2_relock_key", 32'(key_out), 32'h0);
    check("t2_relock_kv", 32'(key_valid), 32'd0);
    send_bits(16'hA5C3, KEY_W);
    send_parity(1'b1);
    check("t2_att1", 32'(attempts), 32'd1);
    check("t2_busy1", 32'(busy), 32'd0);
    load(16'hA5C3);
    send_parity(1'b1);
    check("t2_att2", 32'(attempts), 32'd2);
    check("t2_err2", 32'(err), 32'd0);
    load(16'hA5C3);
    send_parity(1'b1);
    check("t2_err3", 32'(err), 32'd1);
    check("t2_key_out", 32'(key_out), 32'h0);
    check("t2_kv", 32'(key_valid), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("t2_lock_ready", 32'(sif.ser_ready), 32'd0);
    check("t2_lock_busy", 32'(busy), 32'd0);
    check("t2_lock_err", 32'(err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t2_rst_err", 32'(err), 32'd0);
    check("t2_rst_att", 32'(attempts), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // One failure, then a good load of 0x0001 (parity 1) clears attempts.
    load(16'hA5C3);
    send_parity(1'b1);
    check("t3_att1", 32'(attempts), 32'd1);
    load(16'h0001);
    finish_load(1'b1, "t3");
    check("t3_key_valid", 32'(key_valid), 32'd1);
    check("t3_key_out", 32'(key_out), 32'h0001);
    check("t3_att0", 32'(attempts), 32'd0);

    // Leave one failure on the counter so the abort below must preserve it.
    load(16'hA5C3);
    send_parity(1'b1);
`endif

    // start together with abort in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("t4_start_wins", 32'(busy), 32'd1);
    send_bits(16'hFFFF, 7);
    // abort collides with a valid bit: abort wins.
    sif.ser_valid = 1'b1;
    sif.ser_data  = 1'b1;
    abort         = 1'b1;
    step();
    sif.ser_valid = 1'b0;
    abort         = 1'b0;
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_ready", 32'(sif.ser_ready), 32'd0);
`ifdef KEY_LOAD_PARITY_EN
    check("t4_abort_att", 32'(attempts), 32'd1);
`else
    check("t4_abort_att", 32'(attempts), 32'd0);
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_idle_abort", 32'(busy), 32'd0);
    load(16'hFFFF);
    finish_load(1'b0, "t4");
    check("t4_key_out", 32'(key_out), 32'hFFFF);
    check("t4_key_valid", 32'(key_valid), 32'd1);
    check("t4_att0", 32'(attempts), 32'd0);

    // 0x1234 (five ones -> parity 1) with gaps and a stray start pulse.
    begin_load();
    for (int i = 0; i < KEY_W; i++) begin
      if (i % 3 == 1) begin
        sif.ser_valid = 1'b0;
        sif.ser_data  = 1'b1;
        start         = (i == 4);
        step();
        start = 1'b0;
        check("t5_gap_ready", 32'(sif.ser_ready), 32'd1);
      end
      sif.ser_valid = 1'b1;
      sif.ser_data  = (16'h1234 >> i) & 16'h1;
      step();
    end
    sif.ser_valid = 1'b0;
    sif.ser_data  = 1'b0;
    finish_load(1'b1, "t5");
    check("t5_key_out", 32'(key_out), 32'h1234);
    check("t5_key_valid", 32'(key_valid), 32'd1);
    // Valid bits offered in IDLE are not consumed.
    sif.ser_valid = 1'b1;
    step();
    sif.ser_valid = 1'b0;
    check("t5_idle_valid", 32'(busy), 32'd0);
    check("t5_idle_key", 32'(key_out), 32'h1234);

    // Asynchronous reset in the middle of a reload.
    begin_load();
    send_bits(16'h5555, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(sif.ser_ready), 32'd0);
    check("t6_rst_kv", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Commit 0x00F0, then reset asynchronously between edges.
    load(16'h00F0);
    finish_load(1'b0, "t7");
    check("t7_key_out", 32'(key_out), 32'h00F0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_key", 32'(key_out), 32'h0);
    check("t7_rst_kv", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_key_load_ctrl

// File: doc/key_load_ctrl.md
Name: key_load_ctrl

Overview:
Serial key-load controller for the logic-locked c499 datapath (4 MUX-key bits p1..p4, 12 XOR-key bits X_1..X_12).
- Accepts the unlock key bit-serially over a valid/ready link, optionally checks a trailing parity bit, and commits the key to a parallel register driving the locked netlist's key inputs.
- Holds the key at all-zero (locked, corrupted outputs) until a successful load.
- Enters a sticky lockout after repeated parity failures.

Parameters:
KEY_W, 16, key width; key_out[3:0] -> p1..p4, key_out[15:4] -> X_1..X_12
MAX_TRIES, 3, consecutive parity failures before lockout (>=1)
CNT_W, $clog2(KEY_W), bit-counter width
ATT_W, $clog2(MAX_TRIES+1), attempt-counter width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin key load (pulse; sampled in IDLE only)
abort  in  1  discard load in progress
ser_valid  in  1  serial bit valid
ser_data  in  1  serial key bit, LSB first
ser_ready  out  1  controller accepts bit
key_out  out  KEY_W  committed key to locked datapath
key_valid  out  1  key_out holds a committed key
busy  out  1  load in progress (SHIFT/CHECK/COMMIT)
err  out  1  lockout, sticky
attempts  out  ATT_W  consecutive failed loads

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; sreg=0, cnt=0, key_out=0, key_valid=0, busy=0, err=0, ser_ready=0, attempts=0. Reset mid-load drops everything immediately.
- States: IDLE, SHIFT, CHECK, COMMIT, LOCKOUT. All outputs are registered, except ser_ready and busy, which decode from state.
- IDLE: ser_ready=0. On start=1 -> SHIFT, cnt<=0, key_out<=0, key_valid<=0 (datapath re-locked during reload).
- SHIFT: ser_ready=1.
  - Handshake on ser_valid&ser_ready: sreg<={ser_data,sreg[KEY_W-1:1]}, cnt<=cnt+1.
  - Handshake with cnt==KEY_W-1 -> CHECK (parity enabled) or COMMIT (disabled).
- CHECK: ser_ready=1.
  - On handshake, compare ser_data to ^sreg (even parity over key+parity).
  - Match -> COMMIT.
  - Mismatch -> attempts<=attempts+1; if attempts+1==MAX_TRIES -> LOCKOUT, else IDLE.
- COMMIT: one cycle, ser_ready=0; key_out<=sreg, key_valid<=1, attempts<=0 -> IDLE. key_valid is visible the cycle after COMMIT.
- LOCKOUT: err=1, ser_ready=0, key_out=0, key_valid=0; start and abort are ignored. Exit by reset only.
- abort in SHIFT/CHECK -> IDLE, sreg/cnt cleared, attempts unchanged. abort wins over a simultaneous handshake. abort in IDLE/COMMIT has no effect.
- start while busy: ignored. start with abort in IDLE: start wins.
- ser_valid outside SHIFT/CHECK: ignored; no bit consumed.
- Gaps (ser_valid=0) are allowed anywhere; there is no timeout.
- Minimum load with parity: 1 (start) + KEY_W + 1 + 1 cycles to key_valid.

Optional Feature:
KEY_LOAD_PARITY_EN
- Defined: CHECK state, parity compare, attempts counting and LOCKOUT are present.
- Undefined: SHIFT goes directly to COMMIT; CHECK and LOCKOUT are not built; attempts ties to 0 and err ties to 0.

Decomposition:
- Package key_load_pkg: state enum (IDLE, SHIFT, CHECK, COMMIT, LOCKOUT) and KEY_W default.
- Optional sub-module key_shift_reg: LSB-first shift register with bit counter and last-bit flag.
- The FSM, attempt counter and key register stay in the top.

Test Plan:
- Reset, then start; shift 0xA5C3 LSB-first, then parity 0 -> key_valid=1, key_out=0xA5C3, attempts=0, err=0.
- Same key with parity 1, three times -> attempts 1, 2, then err=1 with key_out=0; a further start is ignored with ser_ready=0; rst_n low clears err.
- Parity failure once (attempts=1), then a correct load of 0x0001 with parity 1 -> key_valid=1, attempts=0.
- abort after 7 bits, asserted in the same cycle as ser_valid -> IDLE, bit not consumed, attempts unchanged; a new load of 0xFFFF with parity 0 succeeds.
- ser_valid toggled with random gaps during the 0x1234 load (parity 1) -> key_out=0x1234. start pulsed mid-load -> no effect.
- rst_n asserted asynchronously at bit 9 of a load after a prior committed key -> key_out=0 and key_valid=0 immediately; without KEY_LOAD_PARITY_EN, key_valid rises two cycles after the 16th bit.
